puf_ecc_sequencer: RTL and testbench
====================================

// Module: puf_ecc_sequencer
// PURPOSE
//  Sequences one shared Hamming(15,11) correction core across the full PUF response during key reconstruction.
//  Snapshots the response (N_CHUNKS*K bits) and helper parity (N_CHUNKS*P bits) on i_start.
//  Issues one registered codeword per cycle to the core; captures the corrected 11-bit chunk into o_Data.
//  Uses a start/busy/done handshake. Sits between the PUF response register and the key-derivation stage.
// PARAMETERS
//  N_CHUNKS  24  number of 11-bit chunks; o_Data width = N_CHUNKS*K = 264
//  K         11  data bits per codeword
//  P         4   parity bits per codeword (helper bits per chunk)
// PORTS
//  clk              in   1       rising-edge clock
//  reset            in   1       synchronous, active-high; wins over all other inputs, independent of enable
//  enable           in   1       clock enable; low = all state, counters and outputs frozen
//  i_start          in   1       request; sampled only in IDLE with enable=1
//  i_Data           in   [0:263] raw PUF response; chunk k = i_Data[11k +:11]
//  i_helper         in   [0:95]  helper parity; chunk k = i_helper[4k +:4]
//  o_core_cw        out  [0:14]  registered codeword to the correction core
//  i_core_data      in   [0:10]  corrected data from the core (combinational, same cycle as o_core_cw)
//  o_busy           out  1       high in RUN, DRAIN, DONE
//  o_done           out  1       one-cycle pulse in DONE; o_Data is valid from this cycle until the next accepted start
//  o_Data           out  [0:263] corrected response
// BEHAVIOUR
//  Reset: state=IDLE; idx=0. o_core_cw, o_Data, o_busy and o_done are all 0. Snapshot registers are cleared.
//  Codeword map (d=data chunk, p=parity chunk):
//   cw[0]=p0, cw[1]=p1, cw[2]=d0, cw[3]=p2, cw[4:6]=d1..d3, cw[7]=p3, cw[8:14]=d4..d10.
//  FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE. Transitions occur only when enable=1.
//   IDLE: on i_start, latch i_Data/i_helper into the snapshot, set idx=0, go to RUN.
//         Inputs may change after this; the output reflects the snapshot only.
//   RUN:  each cycle, o_core_cw<=cw(idx) and vld<=1.
//         If vld, o_Data[11*idx_d +:11]<=i_core_data, where idx_d is the previous idx.
//         idx increments; after idx=N_CHUNKS-1 is issued, go to DRAIN.
//   DRAIN: capture the last chunk; clear vld; go to DONE.
//   DONE: o_done=1 for one cycle; go to IDLE.
//  Latency: with the start-sampling edge = E0, chunk k is captured at E(k+2) and o_done rises after E25.
//   The FSM returns to IDLE after E26. With i_start held high, the repeat period is 27 cycles.
//  i_start in RUN, DRAIN or DONE is ignored, not queued.
//  enable low mid-operation: everything holds; completion is delayed by exactly the number of low cycles.
//  Reset mid-operation: IDLE on the next edge; partial o_Data is cleared to 0.
//  idx is a 5-bit counter and never exceeds N_CHUNKS-1; no wrap-around occurs.
// CONFIGURATION
//  PUF_ECC_ERRSTAT_EN defined:
//   Adds input i_core_syn[0:3] (core syndrome).
//   Adds output o_err_cnt[4:0]: number of chunks with a non-zero syndrome, range 0..24.
//   Adds output o_err_map[0:23]: bit k set if chunk k had a non-zero syndrome.
//   Both outputs are cleared on reset and on an accepted start, update at each capture, and hold after done.
//  PUF_ECC_ERRSTAT_EN not defined: those ports and registers are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package puf_ecc_pkg holds:
//   constants CW_W=15, K, P, N_CHUNKS;
//   the state enum {IDLE,RUN,DRAIN,DONE};
//   function pack_cw(d,p), which implements the codeword map.
//  Sub-module puf_cw_pack: combinational chunk select + pack_cw from snapshot and idx, producing cw.
//  The sequencer instantiates puf_cw_pack; the correction core itself is external.
// TESTING (bench core model: combinational Hamming(15,11) corrector)
//  1. Reset, then start with i_Data=0 and i_helper=0 -> o_done after E25; o_Data=0; o_err_cnt=0.
//  2. Chunk k data = k with valid parity; flip cw bit 6 of chunk 5 in the model
//     -> o_Data equals the clean data; o_err_cnt=1; o_err_map=24'h040000.
//  3. Drop enable for 3 cycles when idx=10 -> o_done after E28; o_Data identical to the uninterrupted run.
//  4. Pulse i_start at E5 and change i_Data at E3 -> second start ignored; o_Data matches the E0 snapshot.
//  5. Assert reset when idx=12 -> next cycle o_busy=0, o_done=0, o_Data=0; a following start completes in 25 cycles.
//  6. Hold i_start high -> o_done pulses every 27 cycles; o_busy low for exactly 1 cycle between runs.

Source files
------------

// File: rtl/puf_ecc_pkg.sv
// Shared constants, FSM state type and the Hamming(15,11) codeword packing
// used by the PUF ECC sequencer.
package puf_ecc_pkg;
    localparam int K        = 11;
    localparam int P        = 4;
    localparam int CW_W     = 15;
    localparam int N_CHUNKS = 24;
    localparam int IDX_W    = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Parity bits sit at Hamming positions 1,2,4,8 (cw indices 0,1,3,7).
    function automatic logic [0:CW_W-1] pack_cw(input logic [0:K-1] d, input logic [0:P-1] p);
        logic [0:CW_W-1] cw;
        cw = {p[0], p[1], d[0], p[2], d[1:3], p[3], d[4:10]};
        return cw;
    endfunction
endpackage

// File: rtl/puf_ecc_sequencer_if.sv
// Host-side handshake and data bus of the PUF ECC sequencer.
interface puf_ecc_sequencer_if;
    import puf_ecc_pkg::*;

    logic                  i_start;
    logic [0:N_CHUNKS*K-1] i_Data;
    logic [0:N_CHUNKS*P-1] i_helper;
    logic                  o_busy;
    logic                  o_done;
    logic [0:N_CHUNKS*K-1] o_Data;

    modport master (
        output i_start, i_Data, i_helper,
        input  o_busy, o_done, o_Data
    );

    modport slave (
        input  i_start, i_Data, i_helper,
        output o_busy, o_done, o_Data
    );
endinterface

// File: rtl/puf_cw_pack.sv
// Selects chunk idx of the snapshot (data + helper parity) and packs it
// into a Hamming(15,11) codeword.
module puf_cw_pack
    import puf_ecc_pkg::*;
(
    input  logic [0:N_CHUNKS*K-1] data,
    input  logic [0:N_CHUNKS*P-1] helper,
    input  logic [IDX_W-1:0]      idx,
    output logic [0:CW_W-1]       cw
);
    logic [0:K-1] d_chunk [N_CHUNKS];
    logic [0:P-1] p_chunk [N_CHUNKS];

    for (genvar g = 0; g < N_CHUNKS; g++) begin : g_split
        assign d_chunk[g] = data[g*K +: K];
        assign p_chunk[g] = helper[g*P +: P];
    end

    always_comb begin
        cw = pack_cw(d_chunk[idx], p_chunk[idx]);
    end
endmodule

// File: rtl/puf_ecc_sequencer.sv
// Streams all PUF response chunks through one external Hamming(15,11) core
// and assembles the corrected response. Optional error statistics: PUF_ECC_ERRSTAT_EN.
module puf_ecc_sequencer
    import puf_ecc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    puf_ecc_sequencer_if.slave  bus,
    output logic [0:CW_W-1]     o_core_cw,
    input  logic [0:K-1]        i_core_data
`ifdef PUF_ECC_ERRSTAT_EN
    ,
    input  logic [0:P-1]        i_core_syn,
    output logic [4:0]          o_err_cnt,
    output logic [0:N_CHUNKS-1] o_err_map
`endif
);
    state_t                state;
    state_t                next_state;
    logic [0:N_CHUNKS*K-1] snap_data;
    logic [0:N_CHUNKS*P-1] snap_helper;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_d;
    logic                  vld;
    logic [0:CW_W-1]       cw;
    logic [0:K-1]          result [N_CHUNKS];

    puf_cw_pack u_cw_pack (
        .data   (snap_data),
        .helper (snap_helper),
        .idx    (idx),
        .cw     (cw)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (enable) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.i_start) next_state = RUN;
            RUN:     if (idx == LAST_IDX) next_state = DRAIN;
            DRAIN:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy = (state != IDLE);
        bus.o_done = (state == DONE);
    end

    // The core answers combinationally on the registered codeword, so each
    // capture lands one cycle after its issue, at the previous idx.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_data   <= '0;
            snap_helper <= '0;
            idx         <= '0;
            idx_d       <= '0;
            vld         <= 1'b0;
            o_core_cw   <= '0;
            for (int k = 0; k < N_CHUNKS; k++) result[k] <= '0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        snap_data   <= bus.i_Data;
                        snap_helper <= bus.i_helper;
                        idx         <= '0;
                    end
                end
                RUN: begin
                    o_core_cw <= cw;
                    vld       <= 1'b1;
                    idx_d     <= idx;
                    if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
                end
                DRAIN: vld <= 1'b0;
                default: ;
            endcase
            if (vld) result[idx_d] <= i_core_data;
        end
    end

    for (genvar g = 0; g < N_CHUNKS; g++) begin : g_out
        assign bus.o_Data[g*K +: K] = result[g];
    end

`ifdef PUF_ECC_ERRSTAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_err_cnt <= '0;
            o_err_map <= '0;
        end else if (enable) begin
            if (state == IDLE && bus.i_start) begin
                o_err_cnt <= '0;
                o_err_map <= '0;
            end else if (vld && (|i_core_syn)) begin
                o_err_cnt        <= o_err_cnt + 5'd1;
                o_err_map[idx_d] <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_puf_ecc_sequencer.sv
// Self-checking bench for puf_ecc_sequencer with a behavioural Hamming(15,11)
// core and a run-level reference model.
module tb_puf_ecc_sequencer;
    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [0:14]  core_cw;
    logic [0:10]  core_data;
`ifdef PUF_ECC_ERRSTAT_EN
    logic [0:3]   core_syn;
    logic [4:0]   err_cnt;
    logic [0:23]  err_map;
`endif
    int           tests = 0;
    int           fails = 0;
    bit           checking = 1'b0;
    logic [0:263] clean_vec;

    puf_ecc_sequencer_if bus ();

    puf_ecc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bus         (bus),
        .o_core_cw   (core_cw),
        .i_core_data (core_data)
`ifdef PUF_ECC_ERRSTAT_EN
        ,
        .i_core_syn  (core_syn),
        .o_err_cnt   (err_cnt),
        .o_err_map   (err_map)
`endif
    );

    always #5 clk = ~clk;

    // Hamming positions 1..15; powers of two carry parity, the rest data in order.
    function automatic logic [0:14] place(input logic [0:10] d, input logic [0:3] h);
        logic [0:14] cw;
        int di, hi;
        cw = '0; di = 0; hi = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if ((pos & (pos - 1)) == 0) begin cw[pos-1] = h[hi]; hi++; end
            else begin cw[pos-1] = d[di]; di++; end
        end
        return cw;
    endfunction

    function automatic int syndrome(input logic [0:14] cw);
        int s;
        s = 0;
        for (int pos = 1; pos <= 15; pos++) if (cw[pos-1]) s = s ^ pos;
        return s;
    endfunction

    function automatic logic [0:10] fix_data(input logic [0:14] cw);
        int s, di;
        logic [0:10] d;
        s = syndrome(cw);
        if (s != 0) cw[s-1] = ~cw[s-1];
        d = '0; di = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if ((pos & (pos - 1)) != 0) begin d[di] = cw[pos-1]; di++; end
        end
        return d;
    endfunction

    function automatic logic [0:3] helper_for(input logic [0:10] d);
        int s;
        logic [0:3] h;
        s = syndrome(place(d, 4'b0000));
        for (int j = 0; j < 4; j++) h[j] = s[j];
        return h;
    endfunction

    always_comb begin
        core_data = fix_data(core_cw);
`ifdef PUF_ECC_ERRSTAT_EN
        core_syn  = 4'(syndrome(core_cw));
`endif
    end

    // Reference model: a run lasts 26 enabled edges after the accepted start.
    bit           m_active = 1'b0;
    int           m_e = 0;
    logic [0:263] m_result, exp_data;
    int           m_cnt, exp_cnt;
    logic [0:23]  m_map, exp_map;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0; exp_data = '0; exp_cnt = 0; exp_map = '0;
        end else if (enable) begin
            if (!m_active) begin
                if (bus.i_start) begin
                    m_active = 1'b1; m_e = 0; m_cnt = 0; m_map = '0;
                    exp_cnt = 0; exp_map = '0;
                    for (int k = 0; k < 24; k++) begin
                        logic [0:14] cw;
                        cw = place(bus.i_Data[k*11 +: 11], bus.i_helper[k*4 +: 4]);
                        m_result[k*11 +: 11] = fix_data(cw);
                        if (syndrome(cw) != 0) begin m_cnt++; m_map[k] = 1'b1; end
                    end
                end
            end else begin
                m_e++;
                if (m_e == 25) begin exp_data = m_result; exp_cnt = m_cnt; exp_map = m_map; end
                if (m_e == 26) m_active = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [263:0] act, input logic [263:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("busy", 264'(bus.o_busy), 264'(m_active));
            checkOutput("done", 264'(bus.o_done), 264'(m_active && m_e == 25));
            if (!m_active || m_e == 25) begin
                checkOutput("o_Data", bus.o_Data, exp_data);
`ifdef PUF_ECC_ERRSTAT_EN
                checkOutput("err_cnt", 264'(err_cnt), 264'(exp_cnt));
                checkOutput("err_map", 264'(err_map), 264'(exp_map));
`endif
            end
        end
    end

    // mode 0: all zero; mode 1: chunk k = k, chunk 5 has d3 flipped;
    // mode 2: mixed pattern with data and helper-parity errors.
    task automatic load_pattern(input int mode);
        logic [0:10] c, r;
        logic [0:3]  h;
        for (int k = 0; k < 24; k++) begin
            c = (mode == 0) ? 11'd0 : (mode == 1) ? 11'(k) : 11'(k * 37 + 5);
            h = helper_for(c);
            r = c;
            if (mode == 1 && k == 5) r[3] = ~r[3];
            if (mode == 2 && k % 4 == 1) r[k % 11] = ~r[k % 11];
            if (mode == 2 && k == 10) h[2] = ~h[2];
            clean_vec[k*11 +: 11]  = c;
            bus.i_Data[k*11 +: 11] = r;
            bus.i_helper[k*4 +: 4] = h;
        end
    endtask

    // Entered and left at posedge+2; lat counts edges after the start edge E0.
    task automatic applyStimulus(input int stall_at, input int stall_len,
                                 input int change_at, input int restart_at, output int lat);
        bus.i_start = 1'b1;
        @(posedge clk); #2;
        bus.i_start = 1'b0;
        lat = 0;
        while (!bus.o_done && lat < 100) begin
            if (lat == stall_at) begin
                enable = 1'b0;
                repeat (stall_len) begin @(posedge clk); #2; lat++; end
                enable = 1'b1;
            end
            if (lat == change_at) bus.i_Data = ~bus.i_Data;
            if (lat == restart_at) bus.i_start = 1'b1;
            if (restart_at >= 0 && lat == restart_at + 1) bus.i_start = 1'b0;
            @(posedge clk); #2;
            lat++;
        end
        if (lat >= 100) checkOutput("done_timeout", 264'(lat), 264'(0));
        @(posedge clk); #2;
    endtask

    initial begin
        int lat;
        int done_at[$];
        int lows;
        reset = 1'b1; enable = 1'b1;
        bus.i_start = 1'b0; bus.i_Data = '0; bus.i_helper = '0;
        repeat (2) @(posedge clk);
        #2;
        checking = 1'b1;
        checkOutput("rst_busy", 264'(bus.o_busy), 264'(0));
        checkOutput("rst_done", 264'(bus.o_done), 264'(0));
        checkOutput("rst_data", bus.o_Data, 264'(0));
        checkOutput("rst_cw", 264'(core_cw), 264'(0));
        reset = 1'b0;

        $display("[TB] zero response");
        load_pattern(0);
        applyStimulus(-1, 0, -1, -1, lat);
        checkOutput("t1_lat", 264'(lat), 264'(25));
        checkOutput("t1_data", bus.o_Data, 264'(0));
`ifdef PUF_ECC_ERRSTAT_EN
        checkOutput("t1_cnt", 264'(err_cnt), 264'(0));
`endif

        $display("[TB] single-bit error in chunk 5");
        load_pattern(1);
        applyStimulus(-1, 0, -1, -1, lat);
        checkOutput("t2_lat", 264'(lat), 264'(25));
        checkOutput("t2_data", bus.o_Data, clean_vec);
        checkOutput("t2_chunk5", 264'(bus.o_Data[55 +: 11]), 264'(11'd5));
        checkOutput("t2_chunk23", 264'(bus.o_Data[253 +: 11]), 264'(11'd23));
`ifdef PUF_ECC_ERRSTAT_EN
        checkOutput("t2_cnt", 264'(err_cnt), 264'(1));
        checkOutput("t2_map", 264'(err_map), 264'(24'h040000));
`endif

        $display("[TB] enable stall at idx 10");
        applyStimulus(10, 3, -1, -1, lat);
        checkOutput("t3_lat", 264'(lat), 264'(28));
        checkOutput("t3_data", bus.o_Data, clean_vec);

        $display("[TB] input change and ignored restart");
        load_pattern(2);
        applyStimulus(-1, 0, 3, 4, lat);
        checkOutput("t4_lat", 264'(lat), 264'(25));
        checkOutput("t4_data", bus.o_Data, clean_vec);
        load_pattern(2);

        $display("[TB] reset mid-run");
        bus.i_start = 1'b1;
        @(posedge clk); #2;
        bus.i_start = 1'b0;
        repeat (12) begin @(posedge clk); #2; end
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        checkOutput("t5_busy", 264'(bus.o_busy), 264'(0));
        checkOutput("t5_done", 264'(bus.o_done), 264'(0));
        checkOutput("t5_data", bus.o_Data, 264'(0));
        applyStimulus(-1, 0, -1, -1, lat);
        checkOutput("t5_lat", 264'(lat), 264'(25));
        checkOutput("t5_result", bus.o_Data, clean_vec);

        $display("[TB] start held high");
        lows = 0;
        bus.i_start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #2;
            if (bus.o_done) done_at.push_back(c);
            if (!bus.o_busy && done_at.size() == 1) lows++;
        end
        bus.i_start = 1'b0;
        checkOutput("t6_pulses", 264'(done_at.size()), 264'(2));
        checkOutput("t6_first", 264'(done_at.size() > 0 ? done_at[0] : -1), 264'(25));
        checkOutput("t6_period", 264'(done_at.size() > 1 ? done_at[1] - done_at[0] : -1), 264'(27));
        checkOutput("t6_idle_gap", 264'(lows), 264'(1));
        repeat (30) @(posedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
